// File: rtl/input_cond_pkg.sv
// Shared defaults and helpers for the input conditioner.
// Channels honour INPUT_COND_FALL_EN (fall-pulse generation).
package input_cond_pkg;

    localparam int DEF_N_CH     = 4;
    localparam int DEF_STAGES   = 2;
    localparam int DEF_DEBOUNCE = 3;

    // Counter width: wide enough to hold DEBOUNCE-1, plus one bit of headroom.
    function automatic int cnt_width(input int d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw inputs in, clean levels and edge pulses out.
interface input_conditioner_if #(
    parameter int N_CH = input_cond_pkg::DEF_N_CH
);

    logic [N_CH-1:0] din;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    modport master (
        output din,
        input  level,
        input  rise,
        input  fall
    );

    modport slave (
        input  din,
        output level,
        output rise,
        output fall
    );

endinterface

// File: rtl/cond_channel.sv
// One conditioner channel: synchroniser chain, debounce counter and registered edge pulses.
// The fall-edge register exists only when INPUT_COND_FALL_EN is defined.
module cond_channel
    import input_cond_pkg::*;
#(
    parameter int STAGES   = DEF_STAGES,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CW       = cnt_width(DEBOUNCE);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              s;
    logic              flip;

    assign s = sync_q[STAGES-1];

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], din};
        level_d = level_q;
        cnt_d   = '0;
        flip    = 1'b0;
        // The counter tops out at DEBOUNCE-1, so it never needs to saturate.
        if (s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                flip    = 1'b1;
                level_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = flip && s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

`ifdef INPUT_COND_FALL_EN
    logic fall_q, fall_d;

    assign fall_d = flip && !s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;
`else
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: N_CH independent sync/debounce/edge channels.
// Fall pulses are produced only when INPUT_COND_FALL_EN is defined; otherwise fall reads zero.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int STAGES   = DEF_STAGES,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic                clk,
    input  logic                reset,
    input_conditioner_if.slave  bus
);

    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        cond_channel #(
            .STAGES   (STAGES),
            .DEBOUNCE (DEBOUNCE)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .din   (bus.din[ch]),
            .level (level_w[ch]),
            .rise  (rise_w[ch]),
            .fall  (fall_w[ch])
        );
    end

    assign bus.level = level_w;
    assign bus.rise  = rise_w;
    assign bus.fall  = fall_w;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: cycle table on the default build plus
// hand sequences for async reset and a STAGES=3/DEBOUNCE=1 instance.
module tb_input_conditioner;
    import input_cond_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    input_conditioner_if #(.N_CH(4)) bus ();
    input_conditioner_if #(.N_CH(2)) bus_sw ();

    input_conditioner #(.N_CH(4), .STAGES(2), .DEBOUNCE(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    input_conditioner #(.N_CH(2), .STAGES(3), .DEBOUNCE(1)) dut_sw (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_sw.slave)
    );

    typedef struct {
        logic [3:0] din;
        logic [3:0] lvl;
        logic [3:0] rs;
        logic [3:0] fl;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [3:0] fx(input logic [3:0] x);
`ifdef INPUT_COND_FALL_EN
        return x;
`else
        return 4'b0000;
`endif
    endfunction

    function automatic void add(input logic [3:0] d, input logic [3:0] l,
                                input logic [3:0] r, input logic [3:0] f);
        vec_t v;
        v.din = d;
        v.lvl = l;
        v.rs  = r;
        v.fl  = f;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name,
                       input logic [3:0] al, input logic [3:0] ar, input logic [3:0] af,
                       input logic [3:0] el, input logic [3:0] er, input logic [3:0] ef);
        n_vec++;
        if (al !== el || ar !== er || af !== ef) begin
            n_err++;
            $display("FAIL %s: got level=%b rise=%b fall=%b, want level=%b rise=%b fall=%b",
                     name, al, ar, af, el, er, ef);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.din    = 4'b0000;
        bus_sw.din = 2'b00;

        // Reset state, before any clock edge.
        #1;
        chk("reset_state", bus.level, bus.rise, bus.fall, 4'b0, 4'b0, 4'b0);
        chk("reset_state_sw", {2'b0, bus_sw.level}, {2'b0, bus_sw.rise}, {2'b0, bus_sw.fall},
            4'b0, 4'b0, 4'b0);
        tick();
        tick();
        reset = 1'b0;

        // Clean press on ch0.
        for (int i = 0; i < 7; i++)
            add(4'b0001, (i >= 4) ? 4'b0001 : 4'b0000, (i == 4) ? 4'b0001 : 4'b0000, 4'b0000);
        // Two-cycle glitch on ch1 while ch0 is held.
        for (int i = 0; i < 2; i++) add(4'b0011, 4'b0001, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) add(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        // Release of ch0.
        for (int i = 0; i < 7; i++)
            add(4'b0000, (i >= 4) ? 4'b0000 : 4'b0001, 4'b0000, (i == 4) ? fx(4'b0001) : 4'b0000);
        // Simultaneous step on ch1 and ch3, then release.
        for (int i = 0; i < 7; i++)
            add(4'b1010, (i >= 4) ? 4'b1010 : 4'b0000, (i == 4) ? 4'b1010 : 4'b0000, 4'b0000);
        for (int i = 0; i < 7; i++)
            add(4'b0000, (i >= 4) ? 4'b0000 : 4'b1010, 4'b0000, (i == 4) ? fx(4'b1010) : 4'b0000);
        // Period-2 chatter on ch2 never settles.
        for (int i = 0; i < 10; i++)
            add((i % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 2; i++) add(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        foreach (vecs[k]) begin
            bus.din = vecs[k].din;
            tick();
            chk($sformatf("vec%0d", k), bus.level, bus.rise, bus.fall,
                vecs[k].lvl, vecs[k].rs, vecs[k].fl);
        end

        // Async reset while ch3 is settled high and ch0 is mid-count (cnt=2).
        bus.din = 4'b1000;
        for (int e = 1; e <= 6; e++) tick();
        chk("pre_reset_settled", bus.level, bus.rise, bus.fall, 4'b1000, 4'b0000, 4'b0000);
        bus.din = 4'b1001;
        for (int e = 1; e <= 4; e++) tick();
        reset = 1'b1;
        #1;
        chk("async_reset_clears", bus.level, bus.rise, bus.fall, 4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("post_reset_e%0d", e), bus.level, bus.rise, bus.fall,
                (e >= 5) ? 4'b1001 : 4'b0000, (e == 5) ? 4'b1001 : 4'b0000, 4'b0000);
        end

        // STAGES=3, DEBOUNCE=1: level follows a step after exactly 4 edges.
        bus_sw.din = 2'b01;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("sweep_e%0d", e), {2'b0, bus_sw.level}, {2'b0, bus_sw.rise},
                {2'b0, bus_sw.fall}, (e >= 4) ? 4'b0001 : 4'b0000,
                (e == 4) ? 4'b0001 : 4'b0000, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
